// File: rtl/wgt_fetch_arbiter_if.sv
// Weight-fetch arbiter bundle: configuration, requests, memory read port and
// tagged responses.
//   master : the arbiter (drives memory strobe/address, responses, busy)
//   slave  : the surrounding system (drives config, requests, memory data)
interface wgt_fetch_arbiter_if #(
    parameter int unsigned NUM_REQ      = 8,
    parameter int unsigned WEIGHT_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH   = 24
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic                    cfg_we;
    logic [ID_W-1:0]         cfg_sel;
    logic [ADDR_WIDTH-1:0]   cfg_base;
    logic [ADDR_WIDTH-1:0]   cfg_len;
    logic [NUM_REQ-1:0]      req;
    logic                    mem_rd_en;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [WEIGHT_WIDTH-1:0] mem_rd_data;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [WEIGHT_WIDTH-1:0] rsp_data;
    logic                    busy;

    modport master (
        input  cfg_we, cfg_sel, cfg_base, cfg_len, req, mem_rd_data,
        output mem_rd_en, mem_addr, rsp_valid, rsp_data, busy
    );

    modport slave (
        output cfg_we, cfg_sel, cfg_base, cfg_len, req, mem_rd_data,
        input  mem_rd_en, mem_addr, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/wgt_fetch_arbiter.sv
// Shares one weight-memory read port among NUM_REQ layer consumers.
// Each requester owns a circular base/len region; grants issue fixed
// BURST_LEN-word bursts and read data returns tagged to the grantee.
// Ports: clk; rst_n (synchronous, active-high); bus (wgt_fetch_arbiter_if.master):
//   cfg_we/cfg_sel/cfg_base/cfg_len region config, req level requests,
//   mem_rd_en/mem_addr/mem_rd_data memory port, rsp_valid/rsp_data tagged
//   returns, busy.
// Option: define WGT_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration
//   instead of round-robin.
module wgt_fetch_arbiter #(
    parameter int unsigned NUM_REQ      = 8,
    parameter int unsigned WEIGHT_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH   = 24,
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned RD_LAT       = 2
) (
    input logic                clk,
    input logic                rst_n,
    wgt_fetch_arbiter_if.master bus
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q [NUM_REQ];
    logic [ADDR_WIDTH-1:0] len_q  [NUM_REQ];
    logic [ADDR_WIDTH-1:0] ptr_q  [NUM_REQ];
    logic [ADDR_WIDTH-1:0] off_q  [NUM_REQ];
    logic [ID_W-1:0]       gnt;
    logic [CNT_W-1:0]      cnt;
    logic                  cfg_dirty;
    logic [ADDR_WIDTH-1:0] cur_ptr, cur_off, cur_base, cur_len;
    logic [RD_LAT-1:0]     pipe_vld;
    logic [ID_W-1:0]       pipe_id [RD_LAT];
`ifndef WGT_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       gnt_inc;
    logic [ID_W-1:0]       start;
    logic [ID_W-1:0]       idx;
`endif

    logic [NUM_REQ-1:0]    elig;
    logic                  found;
    logic [ID_W-1:0]       pick;
    logic                  wrap;
    logic [ADDR_WIDTH-1:0] nxt_ptr, nxt_off;
    logic [ADDR_WIDTH-1:0] g_ptr, g_off, g_base, g_len;
    logic                  last;
    logic                  do_grant;

    // Eligibility, arbitration, pointer advance and grant-source selection
    always_comb begin
        elig     = '0;
        found    = 1'b0;
        pick     = '0;
        wrap     = 1'b0;
        nxt_ptr  = '0;
        nxt_off  = '0;
        g_ptr    = '0;
        g_off    = '0;
        g_base   = '0;
        g_len    = '0;
        last     = 1'b0;
        do_grant = 1'b0;
`ifndef WGT_ARB_FIXED_PRIO_EN
        gnt_inc  = '0;
        start    = '0;
        idx      = '0;
`endif

        // A same-cycle config write is already visible to eligibility
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            elig[i] = bus.req[i] &&
                      (((bus.cfg_we && (bus.cfg_sel == ID_W'(i))) ? bus.cfg_len : len_q[i]) != '0);
        end

`ifdef WGT_ARB_FIXED_PRIO_EN
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (elig[k]) begin
                found = 1'b1;
                pick  = ID_W'(k);
            end
        end
`else
        gnt_inc = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);
        // At the end of a burst rr_ptr is being updated to gnt+1 this edge
        start   = (state == BURST) ? gnt_inc : rr_ptr;
        // Descending scan so the first hit from start upward wins
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = ID_W'((int'(start) + k) % int'(NUM_REQ));
            if (elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
`endif

        wrap    = (cur_off == cur_len - ADDR_WIDTH'(1));
        nxt_ptr = wrap ? cur_base : cur_ptr + ADDR_WIDTH'(1);
        nxt_off = wrap ? '0 : cur_off + ADDR_WIDTH'(1);

        last     = (state == BURST) && (cnt == CNT_W'(BURST_LEN - 1));
        do_grant = found && ((state != BURST) || last);

        // Grant source: fresh config, then the grantee's own pending write-back, then stored state
        if (bus.cfg_we && (bus.cfg_sel == pick)) begin
            g_ptr  = bus.cfg_base;
            g_off  = '0;
            g_base = bus.cfg_base;
            g_len  = bus.cfg_len;
        end else if ((state == BURST) && (pick == gnt) && !cfg_dirty) begin
            g_ptr  = nxt_ptr;
            g_off  = nxt_off;
            g_base = base_q[pick];
            g_len  = len_q[pick];
        end else begin
            g_ptr  = ptr_q[pick];
            g_off  = off_q[pick];
            g_base = base_q[pick];
            g_len  = len_q[pick];
        end
    end

    // Control FSM, region tables, response pipeline
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state         <= IDLE;
            gnt           <= '0;
            cnt           <= '0;
            cfg_dirty     <= 1'b0;
            cur_ptr       <= '0;
            cur_off       <= '0;
            cur_base      <= '0;
            cur_len       <= '0;
            pipe_vld      <= '0;
            bus.mem_rd_en <= 1'b0;
            bus.mem_addr  <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.busy      <= 1'b0;
`ifndef WGT_ARB_FIXED_PRIO_EN
            rr_ptr        <= '0;
`endif
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
                ptr_q[i]  <= '0;
                off_q[i]  <= '0;
            end
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            // (valid, id) tags travel alongside the memory latency
            pipe_vld[0] <= bus.mem_rd_en;
            pipe_id[0]  <= gnt;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
            bus.rsp_valid <= pipe_vld[RD_LAT-1] ? (NUM_REQ'(1) << pipe_id[RD_LAT-1]) : '0;
            if (pipe_vld[RD_LAT-1]) begin
                bus.rsp_data <= bus.mem_rd_data;
            end

            case (state)
                IDLE: ;
                BURST: begin
                    if (!last) begin
                        cur_ptr      <= nxt_ptr;
                        cur_off      <= nxt_off;
                        bus.mem_addr <= nxt_ptr;
                        cnt          <= cnt + CNT_W'(1);
                        // Reconfiguring the active requester: keep the old sequence, drop write-back
                        if (bus.cfg_we && (bus.cfg_sel == gnt)) begin
                            cfg_dirty <= 1'b1;
                        end
                    end else begin
                        if (!cfg_dirty) begin
                            ptr_q[gnt] <= nxt_ptr;
                            off_q[gnt] <= nxt_off;
                        end
`ifndef WGT_ARB_FIXED_PRIO_EN
                        rr_ptr <= gnt_inc;
`endif
                        if (!found) begin
                            bus.mem_rd_en <= 1'b0;
                            state         <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!found && (pipe_vld == '0)) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (do_grant) begin
                state         <= BURST;
                gnt           <= pick;
                cnt           <= '0;
                cfg_dirty     <= 1'b0;
                cur_ptr       <= g_ptr;
                cur_off       <= g_off;
                cur_base      <= g_base;
                cur_len       <= g_len;
                bus.mem_addr  <= g_ptr;
                bus.mem_rd_en <= 1'b1;
                bus.busy      <= 1'b1;
            end

            // Config last so it overrides any write-back to the same entry
            if (bus.cfg_we) begin
                base_q[bus.cfg_sel] <= bus.cfg_base;
                len_q[bus.cfg_sel]  <= bus.cfg_len;
                ptr_q[bus.cfg_sel]  <= bus.cfg_base;
                off_q[bus.cfg_sel]  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_wgt_fetch_arbiter.sv
// Testbench for wgt_fetch_arbiter: memory model with fixed read latency and a
// burst-level reference model of region walking and arbitration.
module tb_wgt_fetch_arbiter;
    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned WW      = 16;
    localparam int unsigned AW      = 24;
    localparam int unsigned BL      = 16;
    localparam int unsigned RL      = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    wgt_fetch_arbiter_if #(.NUM_REQ(NUM_REQ), .WEIGHT_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

    wgt_fetch_arbiter #(
        .NUM_REQ(NUM_REQ), .WEIGHT_WIDTH(WW), .ADDR_WIDTH(AW),
        .BURST_LEN(BL), .RD_LAT(RL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] seed_mul = 32'h9E37_79B1;
    logic [31:0] seed_add = 32'h1234_5678;

    function automatic logic [WW-1:0] mem_fn(input logic [AW-1:0] a);
        logic [31:0] t;
        t = 32'(a) * seed_mul + seed_add;
        return t[23:8];
    endfunction

    // Memory: data for the address issued in cycle T is presented in cycle T+RL
    logic [WW-1:0] d_pipe [RL];
    always @(posedge clk) begin
        d_pipe[0] <= mem_fn(bus.mem_addr);
        for (int i = 1; i < int'(RL); i++) d_pipe[i] <= d_pipe[i-1];
    end
    assign bus.mem_rd_data = d_pipe[RL-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Observation of issued reads and returned words
    bit                 rec_en = 1'b0;
    logic [AW-1:0]      obs_a [$];
    int                 obs_c [$];
    logic [NUM_REQ-1:0] rsp_v [$];
    logic [WW-1:0]      rsp_d [$];
    int                 rsp_c [$];

    always @(negedge clk) begin
        if (rec_en) begin
            if (bus.mem_rd_en === 1'b1) begin
                obs_a.push_back(bus.mem_addr);
                obs_c.push_back(cyc);
            end
            if (bus.rsp_valid !== '0) begin
                rsp_v.push_back(bus.rsp_valid);
                rsp_d.push_back(bus.rsp_data);
                rsp_c.push_back(cyc);
            end
        end
    end

    // Reference model: each region is a circular list of words; each grant takes BL of them
    typedef struct { int id; logic [AW-1:0] addr; } exp_t;
    exp_t        exp_q [$];
    int unsigned m_base [NUM_REQ];
    int unsigned m_len  [NUM_REQ];
    int unsigned m_pos  [NUM_REQ];
    int unsigned m_rr;

    function automatic void m_reset();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            m_base[i] = 0; m_len[i] = 0; m_pos[i] = 0;
        end
        m_rr = 0;
        exp_q.delete();
    endfunction

    function automatic void m_cfg(input int i, input int unsigned b, input int unsigned l);
        m_base[i] = b; m_len[i] = l; m_pos[i] = 0;
    endfunction

    function automatic void m_burst(input logic [NUM_REQ-1:0] r);
        int g = -1;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
`ifdef WGT_ARB_FIXED_PRIO_EN
            int c = k;
`else
            int c = int'((m_rr + k) % NUM_REQ);
`endif
            if (g < 0 && r[c] && m_len[c] != 0) g = c;
        end
        if (g < 0) return;
        for (int w = 0; w < int'(BL); w++) begin
            exp_q.push_back('{id: g, addr: AW'(m_base[g] + m_pos[g])});
            m_pos[g] = (m_pos[g] + 1) % m_len[g];
        end
        m_rr = (g + 1) % NUM_REQ;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        bus.req    = '0;
        bus.cfg_we = 1'b0;
        rst_n      = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        m_reset();
    endtask

    task automatic cfg_write(input int sel, input int unsigned b, input int unsigned l);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = 3'(sel);
        bus.cfg_base = AW'(b);
        bus.cfg_len  = AW'(l);
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic start_run(input logic [NUM_REQ-1:0] r);
        obs_a.delete(); obs_c.delete();
        rsp_v.delete(); rsp_d.delete(); rsp_c.delete();
        rec_en  = 1'b1;
        bus.req = r;
    endtask

    task automatic wait_words(input int n, input string name);
        int budget = n * 4 + 100;
        while (obs_a.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (obs_a.size() < n) begin
            errors++;
            $display("FAIL %s timeout: issued %0d words, required %0d", name, obs_a.size(), n);
        end
    endtask

    task automatic finish_run(input string name);
        int budget = 300;
        bus.req = '0;
        while (bus.busy !== 1'b0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_drop: busy=%b after drain window, required 0", name, bus.busy);
        end
        repeat (RL + 3) @(negedge clk);
        rec_en = 1'b0;
    endtask

    task automatic check_run(input int n, input bit b2b, input string name);
        int gap = -1;
        for (int k = 0; k < n && k < obs_a.size(); k++) begin
            logic [NUM_REQ-1:0] oh;
            checks++;
            if (obs_a[k] !== exp_q[k].addr) begin
                errors++;
                $display("FAIL %s addr[%0d]: got %h required %h", name, k, obs_a[k], exp_q[k].addr);
            end
            if (k < rsp_v.size()) begin
                oh = NUM_REQ'(1) << exp_q[k].id;
                checks++;
                if (rsp_c[k] !== obs_c[k] + int'(RL) + 1) begin
                    errors++;
                    $display("FAIL %s rsp_lat[%0d]: got cycle %0d required %0d", name, k, rsp_c[k], obs_c[k] + int'(RL) + 1);
                end
                checks++;
                if (rsp_v[k] !== oh) begin
                    errors++;
                    $display("FAIL %s rsp_valid[%0d]: got %b required %b", name, k, rsp_v[k], oh);
                end
                checks++;
                if (rsp_d[k] !== mem_fn(obs_a[k])) begin
                    errors++;
                    $display("FAIL %s rsp_data[%0d]: got %h required %h", name, k, rsp_d[k], mem_fn(obs_a[k]));
                end
            end
            if (b2b && gap < 0 && obs_c[k] != obs_c[0] + k) gap = k;
        end
        if (b2b) begin
            checks++;
            if (gap >= 0) begin
                errors++;
                $display("FAIL %s back_to_back: bubble before word %0d, required none", name, gap);
            end
        end
        checks++;
        if (obs_a.size() % BL != 0) begin
            errors++;
            $display("FAIL %s burst_len: issued %0d words, required multiple of %0d", name, obs_a.size(), BL);
        end
        checks++;
        if (rsp_v.size() != obs_a.size()) begin
            errors++;
            $display("FAIL %s rsp_count: got %0d responses, required %0d", name, rsp_v.size(), obs_a.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.mem_rd_en, bus.mem_addr, bus.rsp_valid, bus.rsp_data, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_state: en=%b addr=%h rsp_v=%b rsp_d=%h busy=%b required all 0",
                     bus.mem_rd_en, bus.mem_addr, bus.rsp_valid, bus.rsp_data, bus.busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        int seen = 0;
        int budget = 100;
        do_reset();
        cfg_write(0, 'h100, 64);
        bus.req = 8'b0000_0001;
        while (seen < 5 && budget > 0) begin
            @(negedge clk);
            if (bus.mem_rd_en === 1'b1) seen++;
            budget--;
        end
        checks++;
        if (seen < 5) begin
            errors++;
            $display("FAIL reset_mid timeout: saw %0d words, required 5", seen);
        end
        rst_n   = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b0;
        checks++;
        if (bus.mem_rd_en !== 1'b0 || bus.rsp_valid !== '0) begin
            errors++;
            $display("FAIL reset_mid next: en=%b rsp_v=%b required 0/0", bus.mem_rd_en, bus.rsp_valid);
        end
        for (int i = 0; i < int'(RL) + 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== '0) begin
                errors++;
                $display("FAIL reset_mid quiet[%0d]: rsp_v=%b required 0", i, bus.rsp_valid);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        cfg_write(2, 'h40, 40);
        m_cfg(2, 'h40, 40);
        repeat (4) m_burst(8'b0000_0100);
        start_run(8'b0000_0100);
        wait_words(64, "single");
        finish_run("single");
        check_run(64, 1'b1, "single");
    endtask

    task automatic test_round_robin();
        do_reset();
        cfg_write(0, 'h1000, 32); m_cfg(0, 'h1000, 32);
        cfg_write(1, 'h2000, 32); m_cfg(1, 'h2000, 32);
        cfg_write(7, 'h7000, 32); m_cfg(7, 'h7000, 32);
        repeat (6) m_burst(8'b1000_0011);
        start_run(8'b1000_0011);
        wait_words(96, "rr");
        finish_run("rr");
        check_run(96, 1'b1, "rr");
    endtask

    task automatic test_len_zero();
        do_reset();
        cfg_write(4, 'h4000, 0);  m_cfg(4, 'h4000, 0);
        cfg_write(5, 'h5000, 24); m_cfg(5, 'h5000, 24);
        repeat (3) m_burst(8'b0011_0000);
        start_run(8'b0011_0000);
        wait_words(48, "len0");
        finish_run("len0");
        check_run(48, 1'b1, "len0");
    endtask

    task automatic test_cfg_own_burst();
        do_reset();
        cfg_write(3, 'h200, 64);
        m_cfg(3, 'h200, 64);
        m_burst(8'b0000_1000);
        m_cfg(3, 'h800, 64);
        repeat (2) m_burst(8'b0000_1000);
        start_run(8'b0000_1000);
        wait_words(5, "cfg_own");
        cfg_write(3, 'h800, 64);
        wait_words(48, "cfg_own");
        finish_run("cfg_own");
        check_run(48, 1'b0, "cfg_own");
    endtask

`ifdef WGT_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        do_reset();
        cfg_write(0, 'h300, 20); m_cfg(0, 'h300, 20);
        cfg_write(2, 'h900, 20); m_cfg(2, 'h900, 20);
        repeat (4) m_burst(8'b0000_0101);
        start_run(8'b0000_0101);
        wait_words(64, "fixed");
        finish_run("fixed");
        check_run(64, 1'b1, "fixed");
    endtask
`endif

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            logic [NUM_REQ-1:0] r;
            int unsigned        b, l;
            bit                 any = 1'b0;
            do_reset();
            r = NUM_REQ'($urandom);
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                b = $urandom_range(32'h00FF_FFFF);
                l = ($urandom_range(3) == 0) ? 0 : $urandom_range(50, 1);
                cfg_write(i, b, l);
                m_cfg(i, b, l);
                if (r[i] && l != 0) any = 1'b1;
            end
            if (!any) begin
                r[0] = 1'b1;
                cfg_write(0, 'h0FFFF8, 17);
                m_cfg(0, 'h0FFFF8, 17);
            end
            repeat (5) m_burst(r);
            start_run(r);
            wait_words(80, "random");
            finish_run("random");
            check_run(80, 1'b1, "random");
        end
    endtask

    initial begin
        bus.req      = '0;
        bus.cfg_we   = 1'b0;
        bus.cfg_sel  = '0;
        bus.cfg_base = '0;
        bus.cfg_len  = '0;
        seed_mul     = $urandom | 32'h1;
        seed_add     = $urandom;
        test_reset();
        test_reset_mid_burst();
        test_single();
        test_round_robin();
        test_len_zero();
        test_cfg_own_burst();
`ifdef WGT_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
